// File: rtl/aud_pkg.sv
// Shared types and defaults for the audio record/playback sequencer.
// Key indices double as bit positions in the key vector fed to the priority selector.
package aud_pkg;

   localparam int DEF_ADDR_W = 20;
   localparam logic [DEF_ADDR_W-1:0] DEF_MAX_ADDR = 20'hFFFFF;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_REC        = 3'd1,
      S_REC_PAUSE  = 3'd2,
      S_PLAY       = 3'd3,
      S_PLAY_PAUSE = 3'd4
   } aud_state_t;

   // Higher index wins: stop > pause > play > rec
   typedef enum logic [1:0] {
      KEY_REC   = 2'd0,
      KEY_PLAY  = 2'd1,
      KEY_PAUSE = 2'd2,
      KEY_STOP  = 2'd3
   } aud_key_t;

   localparam int NUM_KEYS = 4;

endpackage

// File: rtl/aud_key_prio.sv
// One-hot priority selector: passes only the highest-index key that is asserted.
module aud_key_prio
   import aud_pkg::*;
(
   input  logic [NUM_KEYS-1:0] keys,
   output logic [NUM_KEYS-1:0] sel
);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_KEYS; gi++) begin : g_sel
         if (gi == NUM_KEYS - 1) begin : g_top
            assign sel[gi] = keys[gi];
         end else begin : g_low
            assign sel[gi] = keys[gi] & ~(|keys[NUM_KEYS-1:gi+1]);
         end
      end
   endgenerate

endmodule

// File: rtl/aud_ctrl.sv
// Record/playback sequencer: key pulses in, registered command pulses, SRAM
// ownership and end-of-recording bookkeeping out.
module aud_ctrl
   import aud_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter logic [ADDR_W-1:0] MAX_ADDR = DEF_MAX_ADDR
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_key_rec,
   input  logic              i_key_play,
   input  logic              i_key_pause,
   input  logic              i_key_stop,
   input  logic [ADDR_W-1:0] i_rec_addr,
   input  logic              i_dsp_done,
   output logic              o_rec_start,
   output logic              o_rec_pause,
   output logic              o_rec_stop,
   output logic              o_dsp_start,
   output logic              o_dsp_pause,
   output logic              o_dsp_stop,
   output logic              o_sram_sel,
   output logic              o_sram_we_n,
   output logic [ADDR_W-1:0] o_end_addr,
   output logic              o_has_rec,
   output logic [2:0]        o_state
);

   logic [NUM_KEYS-1:0] key_vec;
   logic [NUM_KEYS-1:0] key_sel;
   logic k_rec, k_play, k_pause, k_stop;

   assign key_vec = {i_key_stop, i_key_pause, i_key_play, i_key_rec};

   aud_key_prio u_prio (
      .keys (key_vec),
      .sel  (key_sel)
   );

   assign k_rec   = key_sel[KEY_REC];
   assign k_play  = key_sel[KEY_PLAY];
   assign k_pause = key_sel[KEY_PAUSE];
   assign k_stop  = key_sel[KEY_STOP];

   aud_state_t        state_reg, state_next;
   logic              rec_start_next, rec_pause_next, rec_stop_next;
   logic              dsp_start_next, dsp_pause_next, dsp_stop_next;
   logic              rec_start_reg, rec_pause_reg, rec_stop_reg;
   logic              dsp_start_reg, dsp_pause_reg, dsp_stop_reg;
   logic              sram_sel_reg, sram_we_n_reg;
   logic [ADDR_W-1:0] end_addr_reg, end_addr_next;
   logic              has_rec_reg, has_rec_next;

   always_comb begin
      state_next     = state_reg;
      rec_start_next = 1'b0;
      rec_pause_next = 1'b0;
      rec_stop_next  = 1'b0;
      dsp_start_next = 1'b0;
      dsp_pause_next = 1'b0;
      dsp_stop_next  = 1'b0;
      end_addr_next  = end_addr_reg;
      has_rec_next   = has_rec_reg;
      case (state_reg)
         S_IDLE: begin
            if (k_rec) begin
               state_next     = S_REC;
               rec_start_next = 1'b1;
               has_rec_next   = 1'b0;
            end else if (k_play && has_rec_reg) begin
               state_next     = S_PLAY;
               dsp_start_next = 1'b1;
            end
         end
         S_REC: begin
            // A full memory stops the recording even if pause is pressed
            if (k_stop || i_rec_addr == MAX_ADDR) begin
               state_next    = S_IDLE;
               rec_stop_next = 1'b1;
               end_addr_next = i_rec_addr;
               has_rec_next  = |i_rec_addr;
            end else if (k_pause) begin
               state_next     = S_REC_PAUSE;
               rec_pause_next = 1'b1;
            end
         end
         S_REC_PAUSE: begin
            if (k_stop) begin
               state_next    = S_IDLE;
               rec_stop_next = 1'b1;
               end_addr_next = i_rec_addr;
               has_rec_next  = |i_rec_addr;
            end else if (k_pause || k_rec) begin
               state_next     = S_REC;
               rec_start_next = 1'b1;
            end
         end
         S_PLAY: begin
            if (k_stop) begin
               state_next    = S_IDLE;
               dsp_stop_next = 1'b1;
            end else if (k_pause) begin
               state_next     = S_PLAY_PAUSE;
               dsp_pause_next = 1'b1;
            end else if (i_dsp_done) begin
               state_next = S_IDLE;
            end
         end
         S_PLAY_PAUSE: begin
            if (k_stop) begin
               state_next    = S_IDLE;
               dsp_stop_next = 1'b1;
            end else if (k_pause || k_play) begin
               state_next     = S_PLAY;
               dsp_start_next = 1'b1;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg     <= S_IDLE;
         rec_start_reg <= 1'b0;
         rec_pause_reg <= 1'b0;
         rec_stop_reg  <= 1'b0;
         dsp_start_reg <= 1'b0;
         dsp_pause_reg <= 1'b0;
         dsp_stop_reg  <= 1'b0;
         sram_sel_reg  <= 1'b0;
         sram_we_n_reg <= 1'b1;
         end_addr_reg  <= '0;
         has_rec_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         rec_start_reg <= rec_start_next;
         rec_pause_reg <= rec_pause_next;
         rec_stop_reg  <= rec_stop_next;
         dsp_start_reg <= dsp_start_next;
         dsp_pause_reg <= dsp_pause_next;
         dsp_stop_reg  <= dsp_stop_next;
         // Decoded from the next state so ownership moves with o_state
         sram_sel_reg  <= (state_next == S_PLAY) || (state_next == S_PLAY_PAUSE);
         sram_we_n_reg <= (state_next != S_REC);
         end_addr_reg  <= end_addr_next;
         has_rec_reg   <= has_rec_next;
      end
   end

   assign o_rec_start = rec_start_reg;
   assign o_rec_pause = rec_pause_reg;
   assign o_rec_stop  = rec_stop_reg;
   assign o_dsp_start = dsp_start_reg;
   assign o_dsp_pause = dsp_pause_reg;
   assign o_dsp_stop  = dsp_stop_reg;
   assign o_sram_sel  = sram_sel_reg;
   assign o_sram_we_n = sram_we_n_reg;
   assign o_end_addr  = end_addr_reg;
   assign o_has_rec   = has_rec_reg;
   assign o_state     = state_reg;

endmodule

// File: doc/aud_ctrl.md
# aud_ctrl

Top-level sequencer for the audio record/playback path. It turns one-cycle key pulses into start, pause and stop pulses for the I2S recorder (`AudRecorder`) and the playback DSP. It decides which engine owns the SRAM and records the last written address, so playback knows where the recording ends. It sits between the debounced key inputs and the recorder/DSP/SRAM mux, in the same clock domain as the recorder.

## Interface
- ADDR_W, 20, SRAM word-address width
- MAX_ADDR, 20'hFFFFF, last usable SRAM address; recording auto-stops here

- i_clk  in  1  system clock (the recorder's bit clock)
- i_rst  in  1  reset, synchronous and active-high
- i_key_rec, i_key_play, i_key_pause, i_key_stop  in  1 each  one-cycle key pulses
- i_rec_addr  in  ADDR_W  recorder's current write address (o_address)
- i_dsp_done  in  1  one-cycle pulse; playback reached o_end_addr
- o_rec_start, o_rec_pause, o_rec_stop  out  1 each  one-cycle pulses to the recorder
- o_dsp_start, o_dsp_pause, o_dsp_stop  out  1 each  one-cycle pulses to the DSP
- o_sram_sel  out  1  0 = recorder owns the SRAM, 1 = DSP owns it
- o_sram_we_n  out  1  active-low SRAM write enable
- o_end_addr  out  ADDR_W  last valid recorded address
- o_has_rec  out  1  a non-empty recording exists
- o_state  out  3  current state code, for the display

## Operation
- States and codes: S_IDLE=0, S_REC=1, S_REC_PAUSE=2, S_PLAY=3, S_PLAY_PAUSE=4.
- Key priority when several keys are high in the same cycle: stop > pause > play > rec. Only the highest-priority key is acted on; the others are dropped.
- S_IDLE:
  - rec → S_REC, pulse o_rec_start, clear o_has_rec.
  - play with o_has_rec=1 → S_PLAY, pulse o_dsp_start.
  - play with o_has_rec=0 is ignored. pause and stop are ignored.
- S_REC:
  - pause → S_REC_PAUSE, pulse o_rec_pause.
  - stop → S_IDLE, pulse o_rec_stop, o_end_addr←i_rec_addr, o_has_rec←(i_rec_addr≠0).
  - i_rec_addr==MAX_ADDR with no stop key → same as stop, with o_end_addr←MAX_ADDR.
  - rec and play are ignored.
- S_REC_PAUSE:
  - pause or rec → S_REC, pulse o_rec_start (resume).
  - stop → same as stop in S_REC.
  - play is ignored.
- S_PLAY:
  - pause → S_PLAY_PAUSE, pulse o_dsp_pause.
  - stop → S_IDLE, pulse o_dsp_stop.
  - i_dsp_done → S_IDLE, no pulse.
  - rec is ignored (stop first).
- S_PLAY_PAUSE:
  - pause or play → S_PLAY, pulse o_dsp_start.
  - stop → S_IDLE, pulse o_dsp_stop.
  - i_dsp_done is ignored.
- SRAM ownership:
  - o_sram_sel=1 in S_PLAY and S_PLAY_PAUSE, otherwise 0.
  - o_sram_we_n=0 only in S_REC.
- o_end_addr and o_has_rec change only on a record stop, on a record start, or on reset.

## Timing
- All outputs are registered.
- A key (or i_dsp_done, or the full condition) sampled at edge N produces the state change and any pulse at edge N+1.
- Every command pulse is high for exactly one cycle.
- o_sram_sel and o_sram_we_n change in the same cycle as o_state.
- A stop in S_REC latches the i_rec_addr value sampled at the stop edge.
- Back-to-back keys in consecutive cycles are each processed against the state updated by the previous key.
- i_dsp_done arriving in the same cycle as a stop: stop wins and o_dsp_stop pulses.
- Reset values: o_state=S_IDLE, all pulses 0, o_sram_sel=0, o_sram_we_n=1, o_end_addr=0, o_has_rec=0.
- Reset asserted during S_REC or S_PLAY: forces the reset values on the next edge. No stop pulse is emitted and the recording is lost.

## Structure
- Package `aud_pkg`: state enum (3-bit), ADDR_W, MAX_ADDR default, and a key-index enum for the priority encoder.
- Sub-module `aud_key_prio`: combinational one-hot priority selector over the four keys, instantiated once.
- FSM, pulse registers and end-address register all live in aud_ctrl.

## Test plan
- Reset, then rec at cycle 10, stop at cycle 50 with i_rec_addr=20'h00123 → o_rec_start at 11, o_rec_stop at 51; o_end_addr=20'h00123, o_has_rec=1, o_state=0.
- play with o_has_rec=0 → no pulse, state stays 0. After the recording above, play → o_dsp_start, o_sram_sel=1; i_dsp_done → o_state=0, o_sram_sel=0.
- rec, pause, pause, stop at i_rec_addr=20'h00040 → pulses o_rec_start, o_rec_pause, o_rec_start, o_rec_stop; o_sram_we_n=1 only in the paused cycles.
- In S_REC, drive i_rec_addr=20'hFFFFF → auto stop with o_rec_stop; o_end_addr=20'hFFFFF.
- pause, play and stop all high in one cycle during S_PLAY → only o_dsp_stop, state 0. stop and i_dsp_done together → o_dsp_stop pulses.
- i_rst high mid-S_PLAY → next edge: o_state=0, o_end_addr=0, o_has_rec=0, no pulses.
